operand_collector: RTL and testbench
====================================

Name: operand_collector

Overview:
- Input stage feeding the Practica III control unit.
- Synchronizes and debounces the raw "enter" push-button, then captures two WIDTH-bit operands from the board switches on two successive presses.
- Once both operands are held, raises inputdata_ready.
- Captures only while the control unit holds loaddata high; otherwise presses are ignored and operands are frozen for the datapath.

Parameters:
- WIDTH, 4, operand width and switch bus width.
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized button must differ from the debounced level before the level flips. Must be ≥2. The board build overrides it to about 500000.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- button  input  1  raw asynchronous push-button, active-high.
- switches  input  WIDTH  operand value presented on the switches.
- loaddata  input  1  capture enable from the control unit.
- operand_a  output  WIDTH  first captured operand.
- operand_b  output  WIDTH  second captured operand.
- inputdata_ready  output  1  high while both operands are held.
- stage  output  2  FSM state for LEDs: 0=WAIT_A, 1=WAIT_B, 2=READY.

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all registers update only on the clk rising edge.
- Reset values:
  - operand_a = 0, operand_b = 0, inputdata_ready = 0, stage = 0 (WAIT_A).
  - Both synchronizer flops, the debounced level db, the previous level db_q, and the debounce counter cnt are all 0.
- Synchronizer: two flops, button→s1→s2. Only s2 is used downstream.
- Debounce, evaluated at every edge:
  - If s2 == db, then cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1, then db <= s2 and cnt <= 0.
  - Otherwise, cnt <= cnt+1.
  - cnt width is clog2(DEBOUNCE_CYCLES)+1. cnt never wraps.
- Press detection: press = db & ~db_q (combinational), where db_q is db delayed one cycle. A release (db falling) generates no event.
- Latency: if button is first sampled high at edge k and stays high, the capture edge is k+DEBOUNCE_CYCLES+2. With the default, that is edge k+6.
- Glitch rejection: a high or low pulse on s2 shorter than DEBOUNCE_CYCLES cycles resets cnt and never changes db.
- FSM, Moore outputs, three states:
  - WAIT_A: if press & loaddata, then operand_a <= switches and go to WAIT_B. Otherwise stay.
  - WAIT_B: if press & loaddata, then operand_b <= switches and go to READY. Otherwise stay.
  - READY: inputdata_ready = 1. Stays until reset; further presses are ignored and operands are frozen.
  - Unused encoding (3): go to WAIT_A.
- Outputs:
  - inputdata_ready is 1 only in READY and is registered from the state.
  - inputdata_ready rises the cycle after operand_b is written, so the operands are stable when it is first seen.
- loaddata low: press is consumed and discarded (no capture, no state change). A press must not be stored and used later.
- Hold-to-repeat is not supported. Holding the button down produces exactly one press; a second capture requires a debounced release followed by a new debounced press.
- Reset mid-operation (any state, including mid-debounce): everything returns to reset values on that edge.
- Button held high through reset release: db starts at 0, so after the normal debounce delay this counts as a press and captures operand_a.
- Simultaneous reset and press: reset wins.
- Switch changes between presses have no effect; only the value present at the capture edge is stored.

Test Plan:
- Reset, then hold loaddata=1 and switches=4'h5. Hold button high from edge 10 → operand_a=5 at edge 16, stage=1, operand_b=0, inputdata_ready=0.
- Release the button for 10 cycles, set switches=4'hA, press again → operand_b=A, stage=2, inputdata_ready=1 one edge later. A third press with switches=4'hF leaves operand_a=5 and operand_b=A unchanged.
- From WAIT_A, apply button pulses high for 1, 2 and 3 cycles separated by 5 low cycles → no capture, stage stays 0, operand_a stays 0.
- loaddata=0 during a full debounced press with switches=4'h3 → operand_a=0, stage=0. Set loaddata=1 without a new press → still no capture. A new press then captures the current switches.
- Hold button high for 50 cycles with switches toggling between 1 and 2 → exactly one capture (the value at edge k+6); stage=1, not 2.
- Assert reset in WAIT_B with cnt mid-count → next cycle all outputs are 0, stage=0. Normal two-press sequence afterwards reaches READY.

Source files
------------

// File: rtl/operand_collector.sv
// operand_collector
//   Input stage for the Practica III control unit. Synchronizes and debounces
//   the raw "enter" push-button. It then captures two WIDTH-bit operands from
//   the board switches on two successive debounced presses. Once both operands
//   are held, it raises inputdata_ready.
//
// Ports
//   clk              system clock, rising edge
//   reset            synchronous, active-high reset
//   button           raw asynchronous push-button, active-high
//   switches         operand value presented on the switches
//   loaddata         capture enable from the control unit
//   operand_a        first captured operand
//   operand_b        second captured operand
//   inputdata_ready  high while both operands are held
//   stage            FSM state for LEDs: 0=WAIT_A, 1=WAIT_B, 2=READY
module operand_collector #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button,
    input  logic [WIDTH-1:0] switches,
    input  logic             loaddata,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             inputdata_ready,
    output logic [1:0]       stage
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        READY  = 2'd2
    } state_t;

    // Two-flop synchronizer; only s2_q is used downstream.
    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             ready_q;

    // Debounce: db follows s2 only after s2 has disagreed with it for
    // DEBOUNCE_CYCLES consecutive edges. Any agreement restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (s2_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_d  = s2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Rising edge of the debounced level only; a release gives no event.
    assign press = db_q & ~db_prev_q;

    // A press while loaddata is low is consumed here: it only lives for one
    // cycle, so nothing is remembered for later.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            WAIT_A: begin
                if (press && loaddata) begin
                    opa_d   = switches;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (press && loaddata) begin
                    opb_d   = switches;
                    state_d = READY;
                end
            end
            READY:   state_d = READY;
            default: state_d = WAIT_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= WAIT_A;
            opa_q     <= '0;
            opb_q     <= '0;
            ready_q   <= 1'b0;
        end else begin
            s1_q      <= button;
            s2_q      <= s1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            // Registered from the current state so the flag rises one cycle
            // after operand_b is written.
            ready_q   <= (state_q == READY);
        end
    end

    assign operand_a       = opa_q;
    assign operand_b       = opb_q;
    assign inputdata_ready = ready_q;
    assign stage           = state_q;

endmodule

// File: tb/tb_operand_collector.sv
module tb_operand_collector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       button = 1'b0;
    logic [3:0] switches = '0;
    logic       loaddata = 1'b0;
    logic [3:0] operand_a, operand_b;
    logic       inputdata_ready;
    logic [1:0] stage;

    int n_checks = 0;
    int n_pass   = 0;

    operand_collector #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .button          (button),
        .switches        (switches),
        .loaddata        (loaddata),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .inputdata_ready (inputdata_ready),
        .stage           (stage)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        button = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({operand_a, operand_b, inputdata_ready, stage} !== 11'd0)
            $display("FAIL reset_outputs: got a=%h b=%h rdy=%b stage=%0d, want all 0",
                     operand_a, operand_b, inputdata_ready, stage);
        else n_pass++;
    endtask

    task automatic test_two_presses();
        loaddata = 1'b1;
        switches = 4'h5;
        button = 1'b1;              // first sampled at edge k
        tick(6);                    // edges k..k+5
        n_checks++;
        if (stage !== 2'd0 || operand_a !== 4'h0)
            $display("FAIL latency_early: got stage=%0d a=%h, want stage=0 a=0", stage, operand_a);
        else n_pass++;
        tick(1);                    // edge k+6
        n_checks++;
        if (operand_a !== 4'h5 || stage !== 2'd1 || operand_b !== 4'h0 || inputdata_ready !== 1'b0)
            $display("FAIL capture_a: got a=%h stage=%0d b=%h rdy=%b, want a=5 stage=1 b=0 rdy=0",
                     operand_a, stage, operand_b, inputdata_ready);
        else n_pass++;
        tick(10);                   // still held: no repeat
        n_checks++;
        if (stage !== 2'd1 || operand_b !== 4'h0)
            $display("FAIL no_repeat: got stage=%0d b=%h, want stage=1 b=0", stage, operand_b);
        else n_pass++;
        button = 1'b0;
        tick(10);
        switches = 4'hA;
        button = 1'b1;
        tick(7);
        n_checks++;
        if (operand_b !== 4'hA || stage !== 2'd2 || inputdata_ready !== 1'b0)
            $display("FAIL capture_b: got b=%h stage=%0d rdy=%b, want b=A stage=2 rdy=0",
                     operand_b, stage, inputdata_ready);
        else n_pass++;
        tick(1);
        n_checks++;
        if (inputdata_ready !== 1'b1)
            $display("FAIL ready_rise: got rdy=%b, want 1", inputdata_ready);
        else n_pass++;
        button = 1'b0;
        tick(10);
        switches = 4'hF;
        button = 1'b1;
        tick(12);
        n_checks++;
        if (operand_a !== 4'h5 || operand_b !== 4'hA || stage !== 2'd2 || inputdata_ready !== 1'b1)
            $display("FAIL ready_frozen: got a=%h b=%h stage=%0d rdy=%b, want a=5 b=A stage=2 rdy=1",
                     operand_a, operand_b, stage, inputdata_ready);
        else n_pass++;
        button = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        loaddata = 1'b1;
        switches = 4'h9;
        for (int w = 1; w <= 3; w++) begin
            button = 1'b1;
            tick(w);
            button = 1'b0;
            tick(5);
        end
        tick(5);
        n_checks++;
        if (stage !== 2'd0 || operand_a !== 4'h0)
            $display("FAIL glitch_reject: got stage=%0d a=%h, want stage=0 a=0", stage, operand_a);
        else n_pass++;
        // Exactly DEBOUNCE_CYCLES high is the shortest pulse that registers.
        switches = 4'h6;
        button = 1'b1;
        tick(4);
        button = 1'b0;
        tick(6);
        n_checks++;
        if (stage !== 2'd1 || operand_a !== 4'h6)
            $display("FAIL pulse_min: got stage=%0d a=%h, want stage=1 a=6", stage, operand_a);
        else n_pass++;
    endtask

    task automatic test_loaddata_low();
        do_reset();
        loaddata = 1'b0;
        switches = 4'h3;
        button = 1'b1;
        tick(10);
        n_checks++;
        if (stage !== 2'd0 || operand_a !== 4'h0)
            $display("FAIL load_low: got stage=%0d a=%h, want stage=0 a=0", stage, operand_a);
        else n_pass++;
        loaddata = 1'b1;
        tick(5);
        n_checks++;
        if (stage !== 2'd0 || operand_a !== 4'h0)
            $display("FAIL no_stored_press: got stage=%0d a=%h, want stage=0 a=0", stage, operand_a);
        else n_pass++;
        button = 1'b0;
        tick(10);
        switches = 4'h7;
        button = 1'b1;
        tick(7);
        n_checks++;
        if (stage !== 2'd1 || operand_a !== 4'h7)
            $display("FAIL load_then_press: got stage=%0d a=%h, want stage=1 a=7", stage, operand_a);
        else n_pass++;
        button = 1'b0;
    endtask

    task automatic test_hold_toggle();
        do_reset();
        loaddata = 1'b1;
        button = 1'b1;
        // Edge k+i sees switches from iteration i; capture edge k+6 sees 1.
        for (int i = 0; i < 50; i++) begin
            switches = (i % 2 == 0) ? 4'h1 : 4'h2;
            tick(1);
        end
        n_checks++;
        if (stage !== 2'd1 || operand_a !== 4'h1 || operand_b !== 4'h0)
            $display("FAIL hold_toggle: got stage=%0d a=%h b=%h, want stage=1 a=1 b=0",
                     stage, operand_a, operand_b);
        else n_pass++;
        button = 1'b0;
        tick(10);
    endtask

    task automatic test_reset_mid();
        // In WAIT_B from the previous test; start a press and stop mid-count.
        button = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_checks++;
        if ({operand_a, operand_b, inputdata_ready, stage} !== 11'd0)
            $display("FAIL reset_mid: got a=%h b=%h rdy=%b stage=%0d, want all 0",
                     operand_a, operand_b, inputdata_ready, stage);
        else n_pass++;
        // Button held through reset release counts as a fresh press.
        switches = 4'h9;
        tick(6);                    // edges k..k+5, k = first edge after reset
        n_checks++;
        if (stage !== 2'd0)
            $display("FAIL held_reset_early: got stage=%0d, want 0", stage);
        else n_pass++;
        tick(1);
        n_checks++;
        if (stage !== 2'd1 || operand_a !== 4'h9)
            $display("FAIL held_reset_capture: got stage=%0d a=%h, want stage=1 a=9", stage, operand_a);
        else n_pass++;
        button = 1'b0;
        tick(10);
        switches = 4'hC;
        button = 1'b1;
        tick(8);
        n_checks++;
        if (stage !== 2'd2 || operand_a !== 4'h9 || operand_b !== 4'hC || inputdata_ready !== 1'b1)
            $display("FAIL after_reset_ready: got stage=%0d a=%h b=%h rdy=%b, want stage=2 a=9 b=C rdy=1",
                     stage, operand_a, operand_b, inputdata_ready);
        else n_pass++;
        button = 1'b0;
    endtask

    task automatic test_reset_wins();
        // Reset asserted on the edge where a capture would otherwise occur.
        do_reset();
        loaddata = 1'b1;
        switches = 4'hE;
        button = 1'b1;
        tick(6);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        button = 1'b0;
        n_checks++;
        if (stage !== 2'd0 || operand_a !== 4'h0)
            $display("FAIL reset_wins: got stage=%0d a=%h, want stage=0 a=0", stage, operand_a);
        else n_pass++;
    endtask

    initial begin
        #1;
        test_reset();
        test_two_presses();
        test_glitch();
        test_loaddata_low();
        test_hold_toggle();
        test_reset_mid();
        test_reset_wins();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
